act_pipe: RTL
=============

ACT_PIPE -- requirements
Module: act_pipe

Interface
REQ-001 Parameter CH, default 8: channel (lane) count.
REQ-002 Parameter DW, default 32: per-lane signed two's-complement data width.
REQ-003 Parameter SW, default 5: width of leak_shift; legal shift values are 0..DW-1.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  act_pipe can accept a beat this cycle.
REQ-008 in_data  input  CH*DW  lane i occupies bits [(i+1)*DW-1 : i*DW].
REQ-009 mode  input  2  activation mode: 00 bypass, 01 ReLU, 10 leaky ReLU, 11 clamped ReLU; sampled with the beat.
REQ-010 leak_shift  input  SW  right-shift amount for mode 10; sampled with the beat.
REQ-011 clamp_max  input  DW  upper bound for mode 11, treated as non-negative (MSB ignored); sampled with the beat.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_ready  input  1  downstream accepts the beat.
REQ-014 out_data  output  CH*DW  result lanes, same packing as in_data.
REQ-015 zero_cnt  output  32  lanes zeroed (present only with ACT_ZERO_COUNT_EN).
REQ-016 cnt_clr  input  1  synchronous clear of zero_cnt (present only with ACT_ZERO_COUNT_EN).

Function
REQ-017 Input handshake is in_valid && in_ready; output handshake is out_valid && out_ready.
REQ-018 Pipeline has exactly 2 register stages: S1 registers the data, the per-lane sign, the per-lane (x > clamp_max) flag, mode, leak_shift and clamp_max; S2 registers the selected result.
REQ-019 Latency is 2 cycles from input handshake to out_valid with no backpressure; throughput is one beat per cycle.
REQ-020 A stage loads when it is empty or its contents move on in the same cycle; in_ready = !S1_valid || S1 moving on; in_ready does not depend on in_valid.
REQ-021 When out_valid && !out_ready, out_data and out_valid hold stable; no beat is dropped or duplicated; up to 2 beats are held.
REQ-022 Mode 00: out = x.
REQ-023 Mode 01: out = (x < 0) ? 0 : x.
REQ-024 Mode 10: out = (x < 0) ? (x >>> leak_shift) : x; arithmetic shift, rounding toward minus infinity (-1 >>> n = -1).
REQ-025 Mode 11: out = (x < 0) ? 0 : (x > clamp_max ? clamp_max : x); clamp_max = 0 forces all lanes to 0.
REQ-026 Mode, leak_shift and clamp_max travel with their beat; a change between beats affects only later beats.
REQ-027 Lanes are fully independent; no lane result depends on another lane.

Reset
REQ-028 While rst = 0: S1_valid = 0, S2_valid = 0, out_valid = 0, out_data = 0, zero_cnt = 0, in_ready = 1.
REQ-029 Reset asserted mid-operation discards all held beats; the first accepted beat after release emerges 2 cycles later.

Configuration
REQ-030 With ACT_ZERO_COUNT_EN defined: zero_cnt adds the number of lanes with x < 0 in modes 01 and 11 at each output handshake; it saturates at 0xFFFFFFFF.
REQ-031 With ACT_ZERO_COUNT_EN defined: cnt_clr = 1 sets zero_cnt to 0 next cycle; clear beats a simultaneous increment, and that beat's count is lost.
REQ-032 Without ACT_ZERO_COUNT_EN: zero_cnt and cnt_clr ports and their logic are absent; all other behaviour is identical.

Structure
REQ-033 Mode encodings (ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLAMP) and default CH/DW/SW values live in the shared package/config include.
REQ-034 The per-lane compute is one sub-module, act_lane, instantiated CH times by a generate loop; handshake and counter logic stay in act_pipe.

Verification
REQ-035 Mode 01, DW=32, lanes {-5, 7, 0, -1, ...}, out_ready=1 -> lanes {0, 7, 0, 0} on out_valid exactly 2 cycles later.
REQ-036 Mode 10, leak_shift=2, lanes {-8, -1, 12} -> {-2, -1, 12}.
REQ-037 Mode 11, clamp_max=6, lanes {-3, 4, 6, 100} -> {0, 4, 6, 6}.
REQ-038 Stream 10 beats with mode toggled each beat and out_ready held low for cycles 3-6 -> all 10 beats out in order with their own modes; in_ready low while both stages are full; out_data stable while stalled.
REQ-039 Assert rst with 2 beats held, then release -> out_valid=0, in_ready=1 immediately; a new beat appears after 2 cycles.
REQ-040 ACT_ZERO_COUNT_EN, CH=8, 3 beats of mode 01 with 4 negative lanes each -> zero_cnt=12; cnt_clr on the same cycle as a 4th beat's output handshake -> zero_cnt=0; preloaded 0xFFFFFFFE plus 4 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/act_pipe_pkg.sv
// Shared definitions for the act_pipe activation pipeline: mode encodings and
// default lane geometry.
package act_pipe_pkg;

  localparam int ACT_CH_DEF = 8;
  localparam int ACT_DW_DEF = 32;
  localparam int ACT_SW_DEF = 5;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10,
    ACT_CLAMP  = 2'b11
  } act_mode_e;

  // Modes that force negative lanes to zero (these lanes feed the zero counter).
  function automatic logic mode_zeroes(input act_mode_e m);
    return (m == ACT_RELU) || (m == ACT_CLAMP);
  endfunction

endpackage

// File: rtl/act_lane.sv
// One activation lane: pre-compare on the incoming beat (sign, above-clamp)
// and result selection on the registered beat. Purely combinational.
module act_lane
  import act_pipe_pkg::*;
#(
  parameter int DW = ACT_DW_DEF,
  parameter int SW = ACT_SW_DEF
) (
  input  logic [DW-1:0] pre_x,
  input  logic [DW-1:0] pre_clamp,
  output logic          pre_neg,
  output logic          pre_gt,
  input  logic [DW-1:0] x,
  input  logic          neg,
  input  logic          gt,
  input  act_mode_e     mode,
  input  logic [SW-1:0] leak_shift,
  input  logic [DW-1:0] clamp_max,
  output logic [DW-1:0] y
);

  assign pre_neg = pre_x[DW-1];
  // pre_clamp has its MSB cleared, so a signed compare is a plain magnitude test.
  assign pre_gt  = $signed(pre_x) > $signed(pre_clamp);

  always_comb begin
    y = x;
    case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU:   if (neg) y = '0;
      ACT_LEAKY:  if (neg) y = $signed(x) >>> leak_shift;
      ACT_CLAMP: begin
        if (neg)     y = '0;
        else if (gt) y = clamp_max;
      end
      default:    y = x;
    endcase
  end

endmodule

// File: rtl/act_pipe.sv
// Two-stage per-lane activation pipeline with valid/ready flow control.
// Optional feature: define ACT_ZERO_COUNT_EN to add the zero_cnt/cnt_clr counter.
module act_pipe
  import act_pipe_pkg::*;
#(
  parameter int CH = ACT_CH_DEF,
  parameter int DW = ACT_DW_DEF,
  parameter int SW = ACT_SW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CH*DW-1:0] in_data,
  input  logic [1:0]     mode,
  input  logic [SW-1:0]  leak_shift,
  input  logic [DW-1:0]  clamp_max,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CH*DW-1:0] out_data
`ifdef ACT_ZERO_COUNT_EN
  ,
  output logic [31:0]    zero_cnt,
  input  logic           cnt_clr
`endif
);

  // Handshakes: a beat transfers on a rising edge where valid && ready.
  // Valid never waits on ready; in_ready never looks at in_valid.
  logic             s1_valid, s2_valid;
  logic [CH*DW-1:0] s1_data, s2_data, lane_y;
  logic [CH-1:0]    s1_neg, s1_gt, pre_neg, pre_gt;
  act_mode_e        s1_mode;
  logic [SW-1:0]    s1_shift;
  logic [DW-1:0]    s1_clamp, clamp_eff;
  logic             s2_open, s1_fwd, in_fire;

  assign clamp_eff = clamp_max & {1'b0, {(DW-1){1'b1}}};
  assign s2_open   = !s2_valid || out_ready;
  assign s1_fwd    = s1_valid && s2_open;
  assign in_ready  = !s1_valid || s2_open;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  for (genvar i = 0; i < CH; i++) begin : g_lane
    act_lane #(.DW(DW), .SW(SW)) u_lane (
      .pre_x      (in_data[i*DW +: DW]),
      .pre_clamp  (clamp_eff),
      .pre_neg    (pre_neg[i]),
      .pre_gt     (pre_gt[i]),
      .x          (s1_data[i*DW +: DW]),
      .neg        (s1_neg[i]),
      .gt         (s1_gt[i]),
      .mode       (s1_mode),
      .leak_shift (s1_shift),
      .clamp_max  (s1_clamp),
      .y          (lane_y[i*DW +: DW])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_neg   <= '0;
      s1_gt    <= '0;
      s1_mode  <= ACT_BYPASS;
      s1_shift <= '0;
      s1_clamp <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_fire) begin
        s1_data  <= in_data;
        s1_neg   <= pre_neg;
        s1_gt    <= pre_gt;
        s1_mode  <= act_mode_e'(mode);
        s1_shift <= leak_shift;
        s1_clamp <= clamp_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (s2_open) s2_valid <= s1_valid;
      if (s1_fwd)  s2_data  <= lane_y;
    end
  end

`ifdef ACT_ZERO_COUNT_EN
  localparam int ZW = $clog2(CH + 1);

  logic [ZW-1:0] s1_zeros, s2_zeros;
  logic [31:0]   zero_cnt_q;
  logic [32:0]   cnt_sum;

  always_comb begin
    s1_zeros = '0;
    if (mode_zeroes(s1_mode)) begin
      for (int i = 0; i < CH; i++) s1_zeros = s1_zeros + ZW'(s1_neg[i]);
    end
  end

  assign cnt_sum  = {1'b0, zero_cnt_q} + 33'(s2_zeros);
  assign zero_cnt = zero_cnt_q;

  // The count of a beat rides in S2 and is added only when that beat leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_zeros   <= '0;
      zero_cnt_q <= '0;
    end else begin
      if (s1_fwd) s2_zeros <= s1_zeros;
      if (cnt_clr)
        zero_cnt_q <= '0;
      else if (s2_valid && out_ready)
        zero_cnt_q <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end
`endif

endmodule
